useq_ctrl: RTL
==============

Name: useq_ctrl

Overview:
- Microsequencer that sits directly upstream of the 23-bit control ROM. It drives the ROM's 5-bit address and consumes the control word returned in the same cycle.
- Sequences the Robertson multiplier microprogram and owns the iteration counter.
- Exports the 15-bit control field to the datapath, plus start/done/err handshake to the host.

Parameters:
- ROM_DEPTH, 18: number of valid microcode words; addresses >= ROM_DEPTH are illegal.
- CNT_W, 4: iteration counter width.
- CNT_INIT, 8: value loaded into the counter (operand width).
- LD_BIT, 13: index within ctrl_word[14:0] that loads the counter.
- DEC_BIT, 3: index within ctrl_word[14:0] that decrements the counter.

Ports:
- clk, input, 1: clock; all state updates on the rising edge.
- reset, input, 1: synchronous, active-high.
- start, input, 1: level request to run the microprogram from address 0.
- status, input, 2: datapath flags. status[0] is the multiplier LSB; status[1] is the sign/compare flag.
- addr, output, 5: uPC, connected to the ROM address.
- data, input, 23: ROM word for addr, combinational, same cycle.
- ctrl, output, 15: datapath control strobes.
- busy, output, 1: high in RUN.
- done, output, 1: high in DONE.
- err, output, 1: sticky illegal-address flag.
- count, output, CNT_W: current iteration count.

Behaviour:
- Microword fields:
  - data[22:20] = cond.
  - data[19:15] = target.
  - data[14:0] = ctrl_word.
- cond encodings:
  - 000: next = uPC+1.
  - 001: next = status[0] ? target : uPC+1.
  - 010: next = status[1] ? target : uPC+1.
  - 011: next = (count==0) ? target : uPC+1.
  - 100: next = target, unconditional.
  - 101-111: reserved; treated as 000.
- Halt: cond==100 and target==uPC.
- uPC+1 is 5-bit and wraps 31->0. Wrap is legal only if the result is < ROM_DEPTH.
- FSM states IDLE, RUN, DONE. Reset -> IDLE with uPC=0, count=0, err=0, busy=0, done=0, ctrl=0.
- IDLE:
  - uPC held at 0; ctrl forced to 0.
  - start=1 -> RUN on the next edge; uPC stays 0, so ROM word 0 executes in the first RUN cycle.
- RUN:
  - Each cycle, ctrl = ctrl_word (combinational from data) and uPC <= next.
  - Halt word -> DONE; the halt word's ctrl is still driven for that cycle.
  - next >= ROM_DEPTH -> err<=1, DONE; uPC is not updated.
- DONE:
  - ctrl=0, done=1, uPC holds.
  - Exit to IDLE requires start=0.
  - start held high stays in DONE; there is no auto-restart.
- Counter (RUN only):
  - ctrl_word[LD_BIT]=1 -> count<=CNT_INIT.
  - Else ctrl_word[DEC_BIT]=1 -> count<=count-1, saturating at 0.
  - LD and DEC in the same word: LD wins.
  - cond 011 samples count before that cycle's update.
- err:
  - Cleared only on reset or on the IDLE->RUN transition.
  - Visible in DONE.
- start deasserted mid-RUN has no effect. The program runs to halt.
- reset mid-RUN: back to IDLE next edge with all outputs at reset values.
- Latency: first ROM word executes 1 cycle after start is sampled. done asserts 1 cycle after the halt word executes.

Optional Feature:
- Macro USEQ_STEP_EN.
- Defined:
  - Adds input step (1 bit).
  - In RUN, uPC, count and state advance only in cycles with step=1. Other cycles hold all of them and force ctrl=0, so datapath strobes fire only on stepped cycles.
  - IDLE/DONE behaviour is unchanged.
- Undefined: no step port; RUN advances every cycle.

Test Plan:
- Reset then start=1 with ROM words 0:cond000, 1:cond000, 2:cond100 target2 -> addr 0,1,2; done=1 on the 4th cycle after start; ctrl=0 in DONE; err=0.
- Word 3 = cond001 target 12; status[0]=1 -> addr 12 next. status[0]=0 -> addr 4.
- Word 0 ctrl[LD_BIT]=1, word 1 ctrl[DEC_BIT]=1 with cond011 target 5 and jump-back loop -> count 8,7,...,0; branch to 5 taken only on the cycle count==0 is sampled; loop executes 8 times.
- Word 17 = cond000 with ROM_DEPTH=18 -> next 18 illegal; err=1, done=1, addr stays 17; next start clears err.
- Assert reset while in RUN at addr 9 -> next cycle addr=0, busy=0, done=0, count=0, ctrl=0, state IDLE.
- With USEQ_STEP_EN: start, then step pulses at cycles 3 and 7 only -> addr changes 0->1 at cycle 3 and 1->2 at cycle 7; ctrl nonzero only in those cycles.

Source files
------------

// File: rtl/useq_ctrl.sv
// useq_ctrl: microsequencer that sits directly upstream of the 23-bit control ROM.
//
// The block drives the ROM address (the uPC). It decodes the microword that the ROM
// returns combinationally in the same cycle. It runs the Robertson multiplier
// microprogram and owns that program's iteration counter.
//
// Microword layout: data[22:20] = cond, data[19:15] = target, data[14:0] = ctrl_word.
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high
//   start      level request to run the microprogram from address 0
//   step       (only with USEQ_STEP_EN) RUN advances only in cycles where step=1
//   status     datapath flags: [0] multiplier LSB, [1] sign/compare flag
//   addr       uPC, drives the ROM address
//   data       ROM word at addr (combinational, same cycle)
//   ctrl       datapath control strobes (zero outside executed RUN cycles)
//   busy       high in RUN
//   done       high in DONE
//   err        sticky illegal-address flag; cleared on reset or IDLE->RUN
//   count      iteration counter
//   dbg_state  FSM state (0 IDLE, 1 RUN, 2 DONE)
//
// Optional feature macro: USEQ_STEP_EN (adds the step input).
//
// Handshake: start is a level. It is sampled in IDLE to enter RUN. It is ignored
// in RUN. In DONE, start must drop before the block returns to IDLE, so there is
// no auto-restart.
module useq_ctrl #(
    parameter int ROM_DEPTH = 18,
    parameter int CNT_W     = 4,
    parameter int CNT_INIT  = 8,
    parameter int LD_BIT    = 13,
    parameter int DEC_BIT   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
`ifdef USEQ_STEP_EN
    input  logic             step,
`endif
    input  logic [1:0]       status,
    output logic [4:0]       addr,
    input  logic [22:0]      data,
    output logic [14:0]      ctrl,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [CNT_W-1:0] count,
    output logic [1:0]       dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [4:0]       upc_q, upc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;

    logic [2:0]  cond;
    logic [4:0]  target;
    logic [14:0] ctrl_word;
    logic [4:0]  upc_inc;
    logic [4:0]  next_pc;
    logic        halt;
    logic        illegal;
    logic        adv;

    assign cond      = data[22:20];
    assign target    = data[19:15];
    assign ctrl_word = data[14:0];

    // The increment wraps 31->0 naturally. The legality check below catches any result outside the ROM.
    assign upc_inc = upc_q + 5'd1;

`ifdef USEQ_STEP_EN
    assign adv = step;
`else
    assign adv = 1'b1;
`endif

    always_comb begin
        next_pc = upc_inc;
        case (cond)
            3'b001:  next_pc = status[0] ? target : upc_inc;
            3'b010:  next_pc = status[1] ? target : upc_inc;
            // The branch tests the count as it stands before this word's LD/DEC takes effect.
            3'b011:  next_pc = (cnt_q == '0) ? target : upc_inc;
            3'b100:  next_pc = target;
            default: next_pc = upc_inc;  // 000 and the reserved codes 101-111
        endcase
    end

    assign halt    = (cond == 3'b100) && (target == upc_q);
    assign illegal = {27'd0, next_pc} >= ROM_DEPTH;

    always_comb begin
        state_d = state_q;
        upc_d   = upc_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        ctrl    = '0;
        case (state_q)
            S_IDLE: begin
                upc_d = '0;
                if (start) begin
                    state_d = S_RUN;
                    err_d   = 1'b0;
                end
            end
            S_RUN: begin
                if (adv) begin
                    ctrl = ctrl_word;
                    // When one word sets both bits, the load takes priority over the decrement.
                    if (ctrl_word[LD_BIT]) begin
                        cnt_d = CNT_W'(CNT_INIT);
                    end else if (ctrl_word[DEC_BIT] && (cnt_q != '0)) begin
                        cnt_d = cnt_q - 1'b1;
                    end
                    if (halt) begin
                        state_d = S_DONE;
                    end else if (illegal) begin
                        // On an illegal next address, uPC stays on the offending word so it can be debugged.
                        err_d   = 1'b1;
                        state_d = S_DONE;
                    end else begin
                        upc_d = next_pc;
                    end
                end
            end
            S_DONE: begin
                if (!start) begin
                    state_d = S_IDLE;
                    upc_d   = '0;
                end
            end
            default: begin
                state_d = S_IDLE;
                upc_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            upc_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    assign addr      = upc_q;
    assign busy      = (state_q == S_RUN);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign count     = cnt_q;
    assign dbg_state = state_q;

endmodule
